// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// FSM state encoding, STATUS bit positions and the reset baud divisor.
// No ports; imported by uart_tx_mmio.
package uart_pkg;

  // Register offsets, selected by addr[3:2].
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // STATUS register bit positions.
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  // Clock cycles per bit after reset.
  localparam logic [15:0] DEFAULT_DIV = 16'd434;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with wrapping read/write pointers.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push while full and pop while empty are ignored.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
// Latency: zero-latency combinational reads; a byte pushed into an idle UART starts its start bit one cycle later.
// Backpressure: none on the bus; a push into a full FIFO is dropped and sets the sticky overflow flag.
// Ports: clk, rst_n (sync, active-low), we/be/op_read/addr/wdata in, rdata out, tx serial out, irq_empty out.
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [2:0]  op_read,
  input  logic [14:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);
  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  // Bus decode
  logic       in_win;
  logic [1:0] sel;
  logic       push;
  logic       ovf_clr;

  assign in_win  = (addr[14:4] == 11'd0);
  assign sel     = addr[3:2];
  assign push    = we && in_win && (sel == REG_TXDATA) && be[0];
  assign ovf_clr = we && in_win && (sel == REG_STATUS) && be[0] && wdata[ST_OVF];

  // FIFO
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control registers
  logic [15:0] baud_q;
  logic        ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_q <= DEFAULT_DIV;
      ovf_q  <= 1'b0;
    end else begin
      if (push && fifo_full) ovf_q <= 1'b1;
      else if (ovf_clr)      ovf_q <= 1'b0;
      if (we && in_win && (sel == REG_BAUD)) begin
        if (be[0]) baud_q[7:0]  <= wdata[7:0];
        if (be[1]) baud_q[15:8] <= wdata[15:8];
      end
    end
  end

  // Serializer FSM
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic [15:0] div_eff;
  logic        bit_end;

  assign div_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign bit_end = (cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 16'd1;
      sh_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          div_d    = div_eff;
          cnt_d    = div_eff - 16'd1;
          bit_d    = 3'd0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = div_q - 16'd1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = div_q - 16'd1;
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Back-to-back frames: the next byte is popped as the stop bit ends.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_dout;
            div_d    = div_eff;
            cnt_d    = div_eff - 16'd1;
            bit_d    = 3'd0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line level tracks the FSM without glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign irq_empty = fifo_empty && (state_q == IDLE);

  // Read path
  logic [31:0] count_ext;
  logic [3:0]  count_sat;

  assign count_ext = 32'(fifo_count);
  assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    rdata = '0;
    if (in_win) begin
      case (sel)
        REG_STATUS: begin
          rdata[ST_EMPTY]          = fifo_empty;
          rdata[ST_FULL]           = fifo_full;
          rdata[ST_BUSY]           = (state_q != IDLE);
          rdata[ST_OVF]            = ovf_q;
          rdata[ST_CNT_LSB +: 4]   = count_sat;
        end
        REG_BAUD: rdata[15:0] = baud_q;
        default:  rdata = '0;
      endcase
    end
  end

  // Bus fields this register set never looks at.
  logic unused_ok;
  assign unused_ok = ^{op_read, addr[1:0], be[3:2], wdata[31:16]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [2:0]  op_read = 3'd0;
  logic [14:0] addr = 15'h4;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  int checks = 0;
  int failures = 0;

  uart_tx_mmio #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .be        (be),
    .op_read   (op_read),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: byte queue plus the current frame described as
  // (byte, cycles elapsed since frame start, cycles per bit).
  logic [7:0] mq[$];
  int         m_baud = 434;
  bit         m_ovf = 1'b0;
  bit         m_in_frame = 1'b0;
  logic [7:0] m_cur = 8'd0;
  int         m_pos = 0;
  int         m_div = 1;

  function automatic logic m_tx();
    int idx;
    if (!m_in_frame) return 1'b1;
    idx = m_pos / m_div;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  function automatic logic [31:0] m_status();
    int n = mq.size();
    logic [31:0] s = 32'd0;
    s[0]   = (n == 0);
    s[1]   = (n == 8);
    s[2]   = m_in_frame;
    s[3]   = m_ovf;
    s[7:4] = 4'((n > 15) ? 15 : n);
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [14:0] a);
    if (a[14:4] != 11'd0) return 32'd0;
    case (a[3:2])
      2'd1:    return m_status();
      2'd2:    return 32'(m_baud);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return (mq.size() == 0) && !m_in_frame;
  endfunction

  // Advance the model by one rising edge using the inputs presented to it.
  task automatic model_edge();
    int pre;
    logic [15:0] b16;
    if (!rst_n) begin
      mq.delete();
      m_in_frame = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
      m_baud = 434;
    end else begin
      pre = mq.size();
      if (m_in_frame) begin
        m_pos++;
        if (m_pos == 10 * m_div) m_in_frame = 1'b0;
      end
      if (!m_in_frame && pre > 0) begin
        m_cur = mq.pop_front();
        m_div = (m_baud == 0) ? 1 : m_baud;
        m_pos = 0;
        m_in_frame = 1'b1;
      end
      if (we && addr[14:4] == 11'd0) begin
        case (addr[3:2])
          2'd0: if (be[0]) begin
            if (pre < 8) mq.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
          end
          2'd1: if (be[0] && wdata[3]) m_ovf = 1'b0;
          2'd2: begin
            b16 = 16'(m_baud);
            if (be[0]) b16[7:0]  = wdata[7:0];
            if (be[1]) b16[15:8] = wdata[15:8];
            m_baud = int'(b16);
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tx", 32'(tx), 32'(m_tx()));
    check("irq_empty", 32'(irq_empty), 32'(m_irq()));
    check("rdata", rdata, m_read(addr));
  endtask

  task automatic wr(input logic [14:0] a, input logic [3:0] b, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    be = b;
    wdata = d;
    op_read = 3'($urandom);
    step();
    we = 1'b0;
    addr = 15'h4;
    be = 4'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (!m_in_frame && mq.size() == 0) break;
      step();
    end
    step();
    check("drain_idle", 32'(irq_empty), 32'd1);
  endtask

  initial begin
    logic [9:0] f55;
    int n;

    // Reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    addr = 15'h4;
    #1;
    check("rst_status", rdata, 32'h1);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq_empty), 32'd1);
    addr = 15'h8;
    #1;
    check("rst_baud", rdata, 32'd434);
    addr = 15'h4;

    // Single frame 0x55 at 4 cycles per bit, checked against the literal line pattern
    wr(15'h8, 4'b0011, 32'd4);
    wr(15'h0, 4'b0001, 32'h55);
    f55 = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 40; c++) begin
      step();
      check("frame55_tx", 32'(tx), 32'(f55[c/4]));
      check("frame55_busy", rdata[2], 32'd1);
    end
    step();
    check("frame55_irq", 32'(irq_empty), 32'd1);

    // Burst of 11 pushes fills the FIFO and overflows, then clear overflow
    for (int i = 0; i < 11; i++) wr(15'h0, 4'b0001, $urandom);
    addr = 15'h4;
    #1;
    check("ovf_set", 32'(rdata[3]), 32'd1);
    check("full_set", 32'(rdata[1]), 32'd1);
    wr(15'h4, 4'b0001, 32'h8);
    #1;
    check("ovf_clr", 32'(rdata[3]), 32'd0);
    drain();

    // Baud change mid-frame only affects the next frame
    wr(15'h0, 4'b0001, 32'hA3);
    repeat (15) step();
    wr(15'h8, 4'b0011, 32'd2);
    drain();
    wr(15'h0, 4'b0001, $urandom);
    n = 0;
    while (!irq_empty && n < 100) begin
      step();
      n++;
    end
    check("len_div2", n, 21);

    // Ignored writes: outside window, reserved register, TXDATA without be[0]
    wr(15'h10, 4'hF, 32'h5A);
    wr(15'hC, 4'hF, 32'hFFFF_FFFF);
    wr(15'h0, 4'b1110, 32'h77);
    addr = 15'h10;
    #1;
    check("rd_outside", rdata, 32'd0);
    addr = 15'hC;
    #1;
    check("rd_reserved", rdata, 32'd0);
    addr = 15'h4;
    #1;
    check("no_push", rdata, 32'h1);

    // Reset in the middle of a data bit drops everything
    wr(15'h8, 4'b0011, 32'd4);
    for (int i = 0; i < 3; i++) wr(15'h0, 4'b0001, $urandom);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_status", rdata, 32'h1);
    repeat (20) step();
    addr = 15'h8;
    #1;
    check("midrst_baud", rdata, 32'd434);
    addr = 15'h4;

    // Randomized traffic against the model
    wr(15'h8, 4'b0011, 32'd3);
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    wr(15'h0, 4'($urandom), $urandom);
        2:       wr(15'h8, 4'($urandom), $urandom_range(0, 5));
        3:       wr(15'h4, 4'($urandom), $urandom);
        4:       wr(15'($urandom), 4'($urandom), $urandom);
        5:       wr(15'hC, 4'hF, $urandom);
        default: step();
      endcase
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
